tap_scan_datapath: RTL and testbench
====================================

# tap_scan_datapath

Scan datapath driven directly by the TAP controller's decoded state strobes. It holds the instruction register (IR) and decodes it into bypass, IDCODE or boundary-scan register selection. It implements capture, shift and update for the selected register and retimes TDO on the falling TCK edge. It sits between the TAP controller and the chip's boundary-scan pins.

## Interface
Parameters:
- IR_WIDTH, 4, instruction register length (≥2)
- BSR_LEN, 8, boundary-scan cell count (≥1)
- IDCODE_VAL, 32'h1000_0001, device ID; bit 0 must be 1

Ports:
- TCK  in  1  scan clock; all state changes on posedge, except TDO/TDO_OE (negedge)
- TRSTn  in  1  asynchronous active-low reset
- TDI  in  1  serial data in
- CaptureDR, ShiftDR, UpdateDR  in  1 each  TAP state strobes, high for the whole state
- CaptureIR, ShiftIR, UpdateIR  in  1 each  TAP state strobes
- Select  in  1  1 = IR drives TDO, 0 = selected DR
- Enable  in  1  TDO output-enable request
- PinIn  in  BSR_LEN  parallel core/pin values captured into the BSR
- PinOut  out  BSR_LEN  BSR update latch
- ExtestMode  out  1  1 while the active instruction is EXTEST
- TDO  out  1  serial data out
- TDO_OE  out  1  TDO driver enable

## Operation
- Opcodes: EXTEST = all-zeros, SAMPLE_PRELOAD = {0…010}, IDCODE = {0…001}, BYPASS = all-ones. Any other opcode decodes as BYPASS.
- IR shift register (ir_sr):
  - CaptureIR: load {0…01} (LSBs 01 per 1149.1).
  - ShiftIR: ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]}; shifted LSB first.
  - UpdateIR: ir_act <= ir_sr.
- DR selection from ir_act: BYPASS → 1-bit bypass reg; IDCODE → 32-bit id_sr; EXTEST/SAMPLE_PRELOAD → BSR shift chain bsr_sr.
- Only the selected DR captures or shifts. The others hold their values.
- Capture values:
  - Bypass: 0
  - id_sr: IDCODE_VAL
  - bsr_sr: PinIn
- ShiftDR: the selected DR shifts right with TDI entering its MSB.
- UpdateDR: PinOut <= bsr_sr, only when the BSR is selected. PinOut holds under all other instructions.
- ExtestMode = (ir_act == EXTEST), combinational from ir_act.
- Serial-out source:
  - Select=1: ir_sr[0]
  - Select=0: LSB of the selected DR
- Simultaneous strobes (illegal from a correct TAP): priority Capture > Shift > Update, IR before DR.

## Timing
- Reset (TRSTn low, asynchronous):
  - ir_sr = {0…01}
  - ir_act = IDCODE (BYPASS when the macro is off)
  - bypass reg = 0, id_sr = 0, bsr_sr = 0, PinOut = 0
  - TDO = 0, TDO_OE = 0, ExtestMode = 0
- Reset asserted mid-shift aborts the shift. No partial update reaches ir_act or PinOut.
- TDO and TDO_OE are registered on negedge TCK from the serial-out mux and Enable. The first shifted bit is therefore visible half a cycle after the posedge that entered the Shift state.
- ir_act changes on the posedge that leaves Update-IR. The new DR selection is used from the next capture.
- Bypass path latency from TDI to TDO is 1 TCK.
- Shifting beyond a register's length wraps nothing: TDI bits fall through and exit at TDO after the register length.

## Configuration
- JTAG_IDCODE_EN defined:
  - 32-bit IDCODE register present.
  - IDCODE opcode selects it.
  - Reset instruction is IDCODE.
- JTAG_IDCODE_EN undefined:
  - No id_sr.
  - IDCODE opcode decodes as BYPASS.
  - Reset instruction is BYPASS.
  - IDCODE_VAL is ignored.

## Structure
- Shared package jtag_pkg:
  - opcode localparams (EXTEST, SAMPLE_PRELOAD, IDCODE, BYPASS)
  - IR capture constant
  - instruction enum type for the decoded selection
- One sub-module: bsr_cell (shift flop plus update latch with mode mux). It is instantiated BSR_LEN times via generate.
- IR, bypass, id_sr and the TDO retime stay in the top.

## Test plan
- Reset then DR scan of 32 bits with TDI=0 → TDO sequence is IDCODE_VAL LSB first (1,0,0,0,…); TDO_OE follows Enable on negedge.
- IR scan shifting in 4'b1111, then UpdateIR, then a DR scan with TDI pattern 1,0,1 → TDO shows 0,1,0,1 (1-bit delay through bypass).
- IR capture → the first two TDO bits during ShiftIR are 1, then 0.
- Load SAMPLE_PRELOAD, PinIn=8'hA5, capture and shift 8 → TDO yields A5 LSB first. Shifting in 8'h3C then UpdateDR → PinOut=8'h3C, ExtestMode=0.
- Load EXTEST (4'b0000) → ExtestMode=1 after UpdateIR. Load unknown opcode 4'b0110 → behaves as BYPASS.
- Assert TRSTn low mid-ShiftDR after 3 bits of a PRELOAD → PinOut stays at its prior value, ir_act returns to IDCODE, TDO=0 and TDO_OE=0 immediately.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG scan definitions: 2-bit opcode seeds, IR capture pattern and decoded selection types.
package jtag_pkg;

  // Opcodes are zero-extended to IR width; BYPASS is its bit replicated to all-ones.
  localparam logic [1:0] OP_EXTEST         = 2'b00;
  localparam logic [1:0] OP_SAMPLE_PRELOAD = 2'b10;
  localparam logic [1:0] OP_IDCODE         = 2'b01;
  localparam logic [1:0] OP_BYPASS         = 2'b11;
  localparam logic [1:0] IR_CAPTURE        = 2'b01;

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_BSR
  } dr_sel_e;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CAPTURE_IR,
    ACT_CAPTURE_DR,
    ACT_SHIFT_IR,
    ACT_SHIFT_DR,
    ACT_UPDATE_IR,
    ACT_UPDATE_DR
  } scan_act_e;

endpackage

// File: rtl/tap_scan_datapath_if.sv
// TAP-side scan bus: state strobes, TDI, Select and Enable from the controller; retimed TDO back.
interface tap_scan_datapath_if;
  logic TDI;
  logic CaptureDR;
  logic ShiftDR;
  logic UpdateDR;
  logic CaptureIR;
  logic ShiftIR;
  logic UpdateIR;
  logic Select;
  logic Enable;
  logic TDO;
  logic TDO_OE;

  modport master (
    output TDI, CaptureDR, ShiftDR, UpdateDR, CaptureIR, ShiftIR, UpdateIR, Select, Enable,
    input  TDO, TDO_OE
  );

  modport slave (
    input  TDI, CaptureDR, ShiftDR, UpdateDR, CaptureIR, ShiftIR, UpdateIR, Select, Enable,
    output TDO, TDO_OE
  );
endinterface

// File: rtl/bsr_cell.sv
// One boundary-scan cell: capture/shift flop (mode mux picks pin or chain) feeding a parallel update latch.
module bsr_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic capture,
  input  logic shift,
  input  logic update,
  input  logic pin_in,
  input  logic scan_in,
  output logic scan_out,
  output logic pin_out
);

  logic mode_d;

  assign mode_d = capture ? pin_in : scan_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      scan_out <= 1'b0;
    else if (capture || shift)
      scan_out <= mode_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pin_out <= 1'b0;
    else if (update)
      pin_out <= scan_out;
  end

endmodule

// File: rtl/tap_scan_datapath.sv
// JTAG scan datapath: IR, bypass, BSR chain and negedge TDO retime.
// Define JTAG_IDCODE_EN to add the 32-bit IDCODE register and make IDCODE the reset instruction.
module tap_scan_datapath
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter int          BSR_LEN    = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                TCK,
  input  logic                TRSTn,
  tap_scan_datapath_if.slave  tap,
  input  logic [BSR_LEN-1:0]  PinIn,
  output logic [BSR_LEN-1:0]  PinOut,
  output logic                ExtestMode
);

  localparam logic [IR_WIDTH-1:0] IR_EXTEST = IR_WIDTH'(OP_EXTEST);
  localparam logic [IR_WIDTH-1:0] IR_SAMPLE = IR_WIDTH'(OP_SAMPLE_PRELOAD);
  localparam logic [IR_WIDTH-1:0] IR_BYPASS = {IR_WIDTH{OP_BYPASS[0]}};
  localparam logic [IR_WIDTH-1:0] IR_CAP    = IR_WIDTH'(IR_CAPTURE);
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_RESET  = IR_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET  = IR_BYPASS;
`endif

  scan_act_e            act;
  dr_sel_e              dr_sel;
  logic [IR_WIDTH-1:0]  ir_sr;
  logic [IR_WIDTH-1:0]  ir_act;
  logic                 bypass_q;
  logic                 id_lsb;
  logic [BSR_LEN:0]     bsr_chain;
  logic                 capture_dr;
  logic                 shift_dr;
  logic                 update_dr;
  logic                 serial_dr;
  logic                 serial_out;

  // Illegal overlapping strobes resolve Capture > Shift > Update, IR before DR.
  always_comb begin
    act = ACT_NONE;
    if (tap.CaptureIR)      act = ACT_CAPTURE_IR;
    else if (tap.CaptureDR) act = ACT_CAPTURE_DR;
    else if (tap.ShiftIR)   act = ACT_SHIFT_IR;
    else if (tap.ShiftDR)   act = ACT_SHIFT_DR;
    else if (tap.UpdateIR)  act = ACT_UPDATE_IR;
    else if (tap.UpdateDR)  act = ACT_UPDATE_DR;
  end

  assign capture_dr = (act == ACT_CAPTURE_DR);
  assign shift_dr   = (act == ACT_SHIFT_DR);
  assign update_dr  = (act == ACT_UPDATE_DR);

  always_ff @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn)
      ir_sr <= IR_CAP;
    else if (act == ACT_CAPTURE_IR)
      ir_sr <= IR_CAP;
    else if (act == ACT_SHIFT_IR)
      ir_sr <= {tap.TDI, ir_sr[IR_WIDTH-1:1]};
  end

  always_ff @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn)
      ir_act <= IR_RESET;
    else if (act == ACT_UPDATE_IR)
      ir_act <= ir_sr;
  end

  // Unlisted opcodes fall through to BYPASS.
  always_comb begin
    dr_sel = SEL_BYPASS;
    if (ir_act == IR_EXTEST || ir_act == IR_SAMPLE)
      dr_sel = SEL_BSR;
`ifdef JTAG_IDCODE_EN
    else if (ir_act == IR_IDCODE)
      dr_sel = SEL_IDCODE;
`endif
  end

  assign ExtestMode = (ir_act == IR_EXTEST);

  always_ff @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn)
      bypass_q <= 1'b0;
    else if (dr_sel == SEL_BYPASS) begin
      if (capture_dr)
        bypass_q <= 1'b0;
      else if (shift_dr)
        bypass_q <= tap.TDI;
    end
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] id_sr;

  always_ff @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn)
      id_sr <= 32'h0;
    else if (dr_sel == SEL_IDCODE) begin
      if (capture_dr)
        id_sr <= IDCODE_VAL;
      else if (shift_dr)
        id_sr <= {tap.TDI, id_sr[31:1]};
    end
  end

  assign id_lsb = id_sr[0];
`else
  // Without the register SEL_IDCODE is never decoded, so this constant never reaches TDO.
  assign id_lsb = IDCODE_VAL[0];
`endif

  assign bsr_chain[BSR_LEN] = tap.TDI;

  for (genvar i = 0; i < BSR_LEN; i++) begin : g_bsr
    bsr_cell u_cell (
      .clk      (TCK),
      .rst_n    (TRSTn),
      .capture  (capture_dr && (dr_sel == SEL_BSR)),
      .shift    (shift_dr && (dr_sel == SEL_BSR)),
      .update   (update_dr && (dr_sel == SEL_BSR)),
      .pin_in   (PinIn[i]),
      .scan_in  (bsr_chain[i+1]),
      .scan_out (bsr_chain[i]),
      .pin_out  (PinOut[i])
    );
  end

  always_comb begin
    serial_dr = bypass_q;
    case (dr_sel)
      SEL_IDCODE: serial_dr = id_lsb;
      SEL_BSR:    serial_dr = bsr_chain[0];
      default:    serial_dr = bypass_q;
    endcase
  end

  assign serial_out = tap.Select ? ir_sr[0] : serial_dr;

  always_ff @(negedge TCK or negedge TRSTn) begin
    if (!TRSTn) begin
      tap.TDO    <= 1'b0;
      tap.TDO_OE <= 1'b0;
    end else begin
      tap.TDO    <= serial_out;
      tap.TDO_OE <= tap.Enable;
    end
  end

endmodule

// File: tb/tb_tap_scan_datapath.sv
// Directed bench for tap_scan_datapath; expectations follow JTAG_IDCODE_EN when it is defined.
module tb_tap_scan_datapath;

  localparam logic [31:0] IDCODE_VAL = 32'h1000_0001;
`ifdef JTAG_IDCODE_EN
  localparam logic [31:0] RESET_DR_WORD = IDCODE_VAL;
  localparam logic [31:0] IDCODE_ONES_WORD = IDCODE_VAL;
`else
  localparam logic [31:0] RESET_DR_WORD = 32'h0;
  localparam logic [31:0] IDCODE_ONES_WORD = 32'hFFFF_FFFE;
`endif

  logic       TCK = 1'b0;
  logic       TRSTn = 1'b1;
  logic [7:0] pin_in = 8'h00;
  logic [7:0] pin_out;
  logic       extest_mode;
  int         checks = 0;
  int         failures = 0;
  logic [32:0] outs;
  logic [4:0]  ir_outs;

  tap_scan_datapath_if tap();

  tap_scan_datapath #(.IR_WIDTH(4), .BSR_LEN(8), .IDCODE_VAL(IDCODE_VAL)) dut (
    .TCK        (TCK),
    .TRSTn      (TRSTn),
    .tap        (tap.slave),
    .PinIn      (pin_in),
    .PinOut     (pin_out),
    .ExtestMode (extest_mode)
  );

  always #5 TCK = ~TCK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Inputs change and outputs are sampled 1 time unit after the falling edge.
  task automatic step();
    @(posedge TCK);
    @(negedge TCK);
    #1;
  endtask

  task automatic clear_strobes();
    tap.CaptureDR = 1'b0; tap.ShiftDR = 1'b0; tap.UpdateDR = 1'b0;
    tap.CaptureIR = 1'b0; tap.ShiftIR = 1'b0; tap.UpdateIR = 1'b0;
    tap.TDI = 1'b0;
  endtask

  task automatic scan_ir(input logic [3:0] v, output logic [4:0] o);
    o = '0;
    tap.Select = 1'b1;
    tap.CaptureIR = 1'b1; step(); tap.CaptureIR = 1'b0;
    for (int i = 0; i < 4; i++) begin
      o[i] = tap.TDO;
      tap.ShiftIR = 1'b1; tap.TDI = v[i]; step();
    end
    o[4] = tap.TDO;
    tap.ShiftIR = 1'b0; tap.TDI = 1'b0; step();
    tap.UpdateIR = 1'b1; step(); tap.UpdateIR = 1'b0;
    tap.Select = 1'b0;
  endtask

  task automatic scan_dr(input int n, input logic [31:0] tdi, output logic [32:0] o);
    o = '0;
    tap.CaptureDR = 1'b1; step(); tap.CaptureDR = 1'b0;
    for (int i = 0; i < n; i++) begin
      o[i] = tap.TDO;
      tap.ShiftDR = 1'b1; tap.TDI = tdi[i]; step();
    end
    o[n] = tap.TDO;
    tap.ShiftDR = 1'b0; tap.TDI = 1'b0; step();
    tap.UpdateDR = 1'b1; step(); tap.UpdateDR = 1'b0;
  endtask

  task automatic test_reset();
    #2 TRSTn = 1'b0;
    step(); step();
    checks++; if (tap.TDO !== 1'b0) begin failures++; $display("[TB] FAIL reset_tdo got=%b want=0", tap.TDO); end
    checks++; if (tap.TDO_OE !== 1'b0) begin failures++; $display("[TB] FAIL reset_tdo_oe got=%b want=0", tap.TDO_OE); end
    checks++; if (extest_mode !== 1'b0) begin failures++; $display("[TB] FAIL reset_extest got=%b want=0", extest_mode); end
    checks++; if (pin_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_pinout got=%h want=00", pin_out); end
    TRSTn = 1'b1;
  endtask

  task automatic test_idcode_after_reset();
    scan_dr(32, 32'h0, outs);
    checks++; if (outs[31:0] !== RESET_DR_WORD) begin failures++; $display("[TB] FAIL reset_dr_scan got=%h want=%h", outs[31:0], RESET_DR_WORD); end
  endtask

  task automatic test_tdo_oe();
    tap.Enable = 1'b1; step();
    checks++; if (tap.TDO_OE !== 1'b1) begin failures++; $display("[TB] FAIL tdo_oe_on got=%b want=1", tap.TDO_OE); end
    tap.Enable = 1'b0; step();
    checks++; if (tap.TDO_OE !== 1'b0) begin failures++; $display("[TB] FAIL tdo_oe_off got=%b want=0", tap.TDO_OE); end
  endtask

  task automatic test_reset_mid_shift();
    scan_ir(4'b0010, ir_outs);
    pin_in = 8'hFF;
    tap.Enable = 1'b1;
    tap.CaptureDR = 1'b1; step(); tap.CaptureDR = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tap.ShiftDR = 1'b1; tap.TDI = 1'b0; step();
    end
    checks++; if ({tap.TDO, tap.TDO_OE} !== 2'b11) begin failures++; $display("[TB] FAIL pre_reset_tdo got=%b want=11", {tap.TDO, tap.TDO_OE}); end
    clear_strobes();
    TRSTn = 1'b0;
    #1;
    checks++; if ({tap.TDO, tap.TDO_OE} !== 2'b00) begin failures++; $display("[TB] FAIL mid_reset_tdo got=%b want=00", {tap.TDO, tap.TDO_OE}); end
    checks++; if (pin_out !== 8'h00) begin failures++; $display("[TB] FAIL mid_reset_pinout got=%h want=00", pin_out); end
    step();
    TRSTn = 1'b1;
    tap.Enable = 1'b0;
    scan_dr(32, 32'h0, outs);
    checks++; if (outs[31:0] !== RESET_DR_WORD) begin failures++; $display("[TB] FAIL mid_reset_instr got=%h want=%h", outs[31:0], RESET_DR_WORD); end
    checks++; if (pin_out !== 8'h00) begin failures++; $display("[TB] FAIL mid_reset_no_update got=%h want=00", pin_out); end
  endtask

  task automatic test_ir_capture_and_bypass();
    scan_ir(4'b1111, ir_outs);
    checks++; if (ir_outs[1:0] !== 2'b01) begin failures++; $display("[TB] FAIL ir_capture_bits got=%b%b want=1,0", ir_outs[0], ir_outs[1]); end
    scan_dr(3, 32'b101, outs);
    checks++; if (outs[3:0] !== 4'b1010) begin failures++; $display("[TB] FAIL bypass_delay got=%b want=1010", outs[3:0]); end
  endtask

  task automatic test_sample_preload();
    scan_ir(4'b0010, ir_outs);
    checks++; if (extest_mode !== 1'b0) begin failures++; $display("[TB] FAIL preload_extest got=%b want=0", extest_mode); end
    pin_in = 8'hA5;
    scan_dr(8, 32'h3C, outs);
    checks++; if (outs[7:0] !== 8'hA5) begin failures++; $display("[TB] FAIL preload_capture got=%h want=a5", outs[7:0]); end
    checks++; if (pin_out !== 8'h3C) begin failures++; $display("[TB] FAIL preload_update got=%h want=3c", pin_out); end
    checks++; if (extest_mode !== 1'b0) begin failures++; $display("[TB] FAIL preload_extest_after got=%b want=0", extest_mode); end
  endtask

  task automatic test_extest();
    scan_ir(4'b0000, ir_outs);
    checks++; if (extest_mode !== 1'b1) begin failures++; $display("[TB] FAIL extest_mode got=%b want=1", extest_mode); end
    checks++; if (pin_out !== 8'h3C) begin failures++; $display("[TB] FAIL extest_hold got=%h want=3c", pin_out); end
    pin_in = 8'h5A;
    scan_dr(8, 32'hC3, outs);
    checks++; if (outs[7:0] !== 8'h5A) begin failures++; $display("[TB] FAIL extest_capture got=%h want=5a", outs[7:0]); end
    checks++; if (pin_out !== 8'hC3) begin failures++; $display("[TB] FAIL extest_update got=%h want=c3", pin_out); end
  endtask

  task automatic test_unknown_opcode();
    scan_ir(4'b0110, ir_outs);
    checks++; if (extest_mode !== 1'b0) begin failures++; $display("[TB] FAIL unknown_extest got=%b want=0", extest_mode); end
    scan_dr(3, 32'b011, outs);
    checks++; if (outs[3:0] !== 4'b0110) begin failures++; $display("[TB] FAIL unknown_bypass got=%b want=0110", outs[3:0]); end
    checks++; if (pin_out !== 8'hC3) begin failures++; $display("[TB] FAIL unknown_pinout_hold got=%h want=c3", pin_out); end
  endtask

  task automatic test_idcode_opcode();
    scan_ir(4'b0001, ir_outs);
    scan_dr(32, 32'hFFFF_FFFF, outs);
    checks++; if (outs[31:0] !== IDCODE_ONES_WORD) begin failures++; $display("[TB] FAIL idcode_opcode got=%h want=%h", outs[31:0], IDCODE_ONES_WORD); end
    checks++; if (pin_out !== 8'hC3) begin failures++; $display("[TB] FAIL idcode_pinout_hold got=%h want=c3", pin_out); end
  endtask

  initial begin
    clear_strobes();
    tap.Select = 1'b0;
    tap.Enable = 1'b0;
    test_reset();
    test_idcode_after_reset();
    test_tdo_oe();
    test_reset_mid_shift();
    test_ir_capture_and_bypass();
    test_sample_preload();
    test_extest();
    test_unknown_opcode();
    test_idcode_opcode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
